// File: rtl/pipe_scroller.sv
// Playfield engine: scrolls three pipe gaps left, recycles them with random bounds, scores passes and detects collisions.
// Latency: every output is registered; a step or a crash shows on the clock edge after the cycle that caused it.
// Backpressure: none; the block free-runs and the view samples gaps directly.
module pipe_scroller #(
  parameter int          HEIGHT     = 40,
  parameter int          WIDTH      = 80,
  parameter int          SCROLL_DIV = 2,
  parameter int          GAP_SIZE   = 10,
  parameter int          SPACING    = 26,
  parameter int          BIRD_COL   = 4,
  parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  altitude,
  output logic [71:0] gaps,
  output logic [7:0]  score,
  output logic        running,
  output logic        dead
);

  typedef enum logic [1:0] {IDLE, RUN, DEAD} state_t;

  localparam int DW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(SCROLL_DIV - 1);
  localparam logic [7:0] POS_NEW  = 8'(3 * SPACING);
  localparam logic [7:0] MIN_INIT = 8'd15;
  localparam logic [7:0] MAX_INIT = 8'd25;
  localparam logic [7:0] GAP      = 8'(GAP_SIZE);
  localparam logic [7:0] LIM      = 8'(HEIGHT - GAP_SIZE - 4);
  localparam logic [7:0] BCOL     = 8'(BIRD_COL);
  localparam logic [8:0] BCOL9    = 9'(BIRD_COL);
  localparam logic [8:0] BCOL_HI9 = 9'(BIRD_COL + 2);
  localparam logic [7:0] POS_INIT [3] = '{8'(WIDTH), 8'(WIDTH + SPACING), 8'(WIDTH + 2 * SPACING)};

  state_t          state_q, state_d;
  logic [7:0]      pos_q [3];
  logic [7:0]      pos_d [3];
  logic [7:0]      min_q [3];
  logic [7:0]      min_d [3];
  logic [7:0]      max_q [3];
  logic [7:0]      max_d [3];
  logic [7:0]      score_q, score_d;
  logic [7:0]      lfsr_q, lfsr_d;
  logic [DW-1:0]   div_q, div_d;
  logic            running_q, running_d;
  logic            dead_q, dead_d;

  logic            crash;
  logic            step;
  logic [1:0]      n_pass;
  logic [8:0]      score_sum;
  logic [7:0]      rnd;
  logic [7:0]      min_new;
  logic [7:0]      max_new;

  // Collision test on the registered gaps; 9-bit compares avoid underflow near column 0
  always_comb begin
    crash = (altitude == 8'd0);
    for (int i = 0; i < 3; i++) begin
      if (({1'b0, pos_q[i]} + 9'd2 >= BCOL9) && ({1'b0, pos_q[i]} <= BCOL_HI9) &&
          (({1'b0, altitude} >= {1'b0, max_q[i]}) || ({1'b0, altitude} <= {1'b0, min_q[i]}))) begin
        crash = 1'b1;
      end
    end
  end

  // New gap bounds for any pipe recycled this step; folds the top of the 5-bit range back down
  always_comb begin
    rnd     = {3'b000, lfsr_q[4:0]};
    min_new = 8'd2 + ((rnd > LIM) ? (rnd - 8'd16) : rnd);
    max_new = min_new + GAP;
  end

  // Next-state logic: FSM, scroll divider, per-pipe scroll/recycle and saturating score
  always_comb begin
    state_d   = state_q;
    score_d   = score_q;
    div_d     = div_q;
    lfsr_d    = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    step      = 1'b0;
    n_pass    = 2'd0;
    score_sum = 9'd0;
    for (int i = 0; i < 3; i++) begin
      pos_d[i] = pos_q[i];
      min_d[i] = min_q[i];
      max_d[i] = max_q[i];
    end
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          div_d   = '0;
        end
      end
      RUN: begin
        // A crash freezes the playfield on this edge even if a step was due
        if (crash) begin
          state_d = DEAD;
        end else begin
          step  = (div_q == DIV_LAST);
          div_d = step ? '0 : div_q + 1'b1;
          if (step) begin
            for (int i = 0; i < 3; i++) begin
              n_pass = n_pass + {1'b0, (pos_q[i] == BCOL)};
              if (pos_q[i] == 8'd1) begin
                pos_d[i] = POS_NEW;
                min_d[i] = min_new;
                max_d[i] = max_new;
              end else begin
                pos_d[i] = pos_q[i] - 8'd1;
              end
            end
            score_sum = {1'b0, score_q} + {7'd0, n_pass};
            score_d   = score_sum[8] ? 8'hFF : score_sum[7:0];
          end
        end
      end
      DEAD: begin
        // Re-arm: playfield returns to its power-on layout, LFSR keeps running
        if (start) begin
          state_d = IDLE;
          score_d = 8'd0;
          div_d   = '0;
          for (int i = 0; i < 3; i++) begin
            pos_d[i] = POS_INIT[i];
            min_d[i] = MIN_INIT;
            max_d[i] = MAX_INIT;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    running_d = (state_d == RUN);
    dead_d    = (state_d == DEAD);
  end

  // State register with asynchronous reset to the initial playfield
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      score_q   <= 8'd0;
      div_q     <= '0;
      lfsr_q    <= LFSR_SEED;
      running_q <= 1'b0;
      dead_q    <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        pos_q[i] <= POS_INIT[i];
        min_q[i] <= MIN_INIT;
        max_q[i] <= MAX_INIT;
      end
    end else begin
      state_q   <= state_d;
      score_q   <= score_d;
      div_q     <= div_d;
      lfsr_q    <= lfsr_d;
      running_q <= running_d;
      dead_q    <= dead_d;
      for (int i = 0; i < 3; i++) begin
        pos_q[i] <= pos_d[i];
        min_q[i] <= min_d[i];
        max_q[i] <= max_d[i];
      end
    end
  end

  assign gaps    = {pos_q[0], max_q[0], min_q[0],
                    pos_q[1], max_q[1], min_q[1],
                    pos_q[2], max_q[2], min_q[2]};
  assign score   = score_q;
  assign running = running_q;
  assign dead    = dead_q;

endmodule

// File: tb/tb_pipe_scroller.sv
// Self-checking bench for pipe_scroller: random bird altitudes against a behavioural playfield model.
// Latency: model advances once per active edge, outputs compared 1 ns later.
// Backpressure: not applicable.
module tb_pipe_scroller;
  localparam int HEIGHT     = 40;
  localparam int WIDTH      = 80;
  localparam int SCROLL_DIV = 2;
  localparam int GAP_SIZE   = 10;
  localparam int SPACING    = 26;
  localparam int BIRD_COL   = 4;
  localparam logic [71:0] IDLE_GAPS = 72'h50190F_6A190F_84190F;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  altitude = 8'd20;
  logic [71:0] gaps;
  logic [7:0]  score;
  logic        running;
  logic        dead;

  pipe_scroller #(
    .HEIGHT(HEIGHT), .WIDTH(WIDTH), .SCROLL_DIV(SCROLL_DIV), .GAP_SIZE(GAP_SIZE),
    .SPACING(SPACING), .BIRD_COL(BIRD_COL), .LFSR_SEED(8'hA5)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .altitude(altitude),
    .gaps(gaps), .score(score), .running(running), .dead(dead)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model: plain integers, run-cycle count instead of a divider
  int         m_pos [3];
  int         m_min [3];
  int         m_max [3];
  int         m_score;
  int         m_state;      // 0 idle, 1 run, 2 dead
  int         m_run_cycles;
  logic [7:0] m_lfsr;

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reinit();
    for (int i = 0; i < 3; i++) begin
      m_pos[i] = WIDTH + i * SPACING;
      m_min[i] = 15;
      m_max[i] = 25;
    end
    m_score      = 0;
    m_run_cycles = 0;
  endtask

  task automatic model_reset();
    model_reinit();
    m_state = 0;
    m_lfsr  = 8'hA5;
  endtask

  function automatic logic [71:0] m_gaps();
    logic [71:0] g;
    g = '0;
    for (int i = 0; i < 3; i++)
      g = {g[47:0], 8'(m_pos[i]), 8'(m_max[i]), 8'(m_min[i])};
    return g;
  endfunction

  task automatic model_edge();
    int  a, r, n;
    bit  crash;
    a = int'(altitude);
    crash = (a == 0);
    for (int i = 0; i < 3; i++)
      if (m_pos[i] >= BIRD_COL - 2 && m_pos[i] <= BIRD_COL + 2 && (a >= m_max[i] || a <= m_min[i]))
        crash = 1'b1;
    case (m_state)
      0: if (start) begin m_state = 1; m_run_cycles = 0; end
      1: begin
        if (crash) m_state = 2;
        else begin
          m_run_cycles++;
          if (m_run_cycles % SCROLL_DIV == 0) begin
            n = 0;
            r = int'(m_lfsr[4:0]);
            for (int i = 0; i < 3; i++) begin
              if (m_pos[i] == BIRD_COL) n++;
              if (m_pos[i] == 1) begin
                m_pos[i] = 3 * SPACING;
                m_min[i] = 2 + ((r > HEIGHT - GAP_SIZE - 4) ? r - 16 : r);
                m_max[i] = m_min[i] + GAP_SIZE;
              end else m_pos[i] = m_pos[i] - 1;
            end
            m_score = (m_score + n > 255) ? 255 : m_score + n;
          end
        end
      end
      default: if (start) begin model_reinit(); m_state = 0; end
    endcase
    m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check("gaps", gaps, m_gaps());
    check("score", score, 72'(m_score));
    check("running", running, m_state == 1);
    check("dead", dead, m_state == 2);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  // Midpoint of the nearest pipe not yet behind the bird
  function automatic int smart_alt();
    int best;
    best = -1;
    for (int i = 0; i < 3; i++)
      if (m_pos[i] >= BIRD_COL - 2 && (best < 0 || m_pos[i] < m_pos[best])) best = i;
    return (m_min[best] + m_max[best]) / 2;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [71:0] snap_g;
    logic [7:0]  snap_s;
    int          cnt;
    model_reset();
    #12 rst_n = 1'b1;
    check("rst_gaps", gaps, IDLE_GAPS);
    check("rst_score", score, 0);
    check("rst_running", running, 0);
    check("rst_dead", dead, 0);

    repeat (100) cycle();
    check("idle_gaps", gaps, IDLE_GAPS);
    check("idle_running", running, 0);

    // Start and early scrolling
    altitude = 8'd20;
    pulse_start();
    check("run_after_start", running, 1);
    repeat (2) cycle();
    check("p1_pos_2clk", gaps[71:64], 79);
    repeat (18) cycle();
    check("p1_pos_20clk", gaps[71:64], 70);
    check("p2_pos_20clk", gaps[47:40], 96);
    check("p3_pos_20clk", gaps[23:16], 122);

    // First pass scores, then pipe1 recycles
    cnt = 0;
    while (gaps[71:64] != 8'd3 && cnt < 400) begin
      altitude = 8'(smart_alt()); cycle(); cnt++;
    end
    check("reach_pos3", cnt < 400, 1);
    check("score_first_pass", score, 1);
    cnt = 0;
    while (gaps[71:64] != 8'(3 * SPACING) && cnt < 50) begin
      altitude = 8'(smart_alt()); cycle(); cnt++;
    end
    check("recycle_pos", gaps[71:64], 3 * SPACING);
    check("recycle_min_range", (gaps[55:48] >= 8'd2) && (gaps[55:48] <= 8'd28), 1);
    check("recycle_max", gaps[63:56], 72'(gaps[55:48]) + GAP_SIZE);

    // Crash on a cycle that would also have stepped
    while ((m_run_cycles + 1) % SCROLL_DIV != 0) begin
      altitude = 8'(smart_alt()); cycle();
    end
    snap_g = gaps; snap_s = score;
    altitude = 8'd0;
    cycle();
    check("coll_step_gaps", gaps, snap_g);
    check("coll_step_score", score, snap_s);
    check("coll_step_dead", dead, 1);
    repeat (5) cycle();
    pulse_start();
    check("rearm_gaps", gaps, IDLE_GAPS);
    check("rearm_score", score, 0);
    check("rearm_dead", dead, 0);

    // Low bird hits pipe1 as it enters the collision window
    altitude = 8'd5;
    pulse_start();
    cnt = 0;
    while (gaps[71:64] != 8'd6 && cnt < 400) begin cycle(); cnt++; end
    check("low_dead_before", dead, 0);
    cycle();
    check("low_dead_after", dead, 1);
    snap_g = gaps; snap_s = score;
    repeat (50) cycle();
    check("frozen_gaps", gaps, snap_g);
    check("frozen_score", score, snap_s);
    pulse_start();

    // Randomized runs with a mostly-competent bird
    for (int run = 0; run < 6; run++) begin
      pulse_start();
      for (int k = 0; k < 400 && m_state == 1; k++) begin
        if ($urandom_range(0, 24) == 0) altitude = 8'($urandom_range(0, 60));
        else altitude = 8'(smart_alt() + int'($urandom_range(0, 4)) - 2);
        start = ($urandom_range(0, 15) == 0);
        cycle();
      end
      start = 1'b0;
      if (m_state == 1) begin altitude = 8'd0; cycle(); end
      repeat (int'($urandom_range(1, 8))) cycle();
      pulse_start();
    end

    // Asynchronous reset in the middle of a run
    pulse_start();
    for (int k = 0; k < 200; k++) begin altitude = 8'(smart_alt()); cycle(); end
    #3 rst_n = 1'b0;
    #1;
    check("arst_gaps", gaps, IDLE_GAPS);
    check("arst_score", score, 0);
    check("arst_running", running, 0);
    check("arst_dead", dead, 0);
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    altitude = 8'd20;
    repeat (3) cycle();
    pulse_start();
    for (int k = 0; k < 60; k++) begin altitude = 8'(smart_alt()); cycle(); end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
